// File: rtl/dot4su_pkg.sv
// -----------------------------------------------------------------------------
// dot4su_pkg
//
// Shared definitions for the dot4su streaming dot-product accumulator:
//   PROD_W / PROD_MIN / PROD_MAX : width and value range of the incoming
//                                  signed x unsigned 4x4 products
//   state_e                      : accumulator FSM state encoding
//   cnt_width()                  : width of the term counter for a given LEN
//
// Optional feature macro used by the files importing this package:
//   DOT4SU_SAT_EN  - saturate instead of wrap on accumulator overflow.
// -----------------------------------------------------------------------------
package dot4su_pkg;

  localparam int PROD_W   = 8;
  localparam int PROD_MIN = -120;
  localparam int PROD_MAX = 105;

  // ACCUM: collecting terms, no result waiting.
  // HOLD : a finished result is presented and has not been taken yet.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Counter width for LEN terms (indices 0..LEN-1). LEN=2 still needs one bit.
  function automatic int cnt_width(input int len);
    if (len <= 2) begin
      return 1;
    end
    return $clog2(len);
  endfunction

endpackage : dot4su_pkg

// File: rtl/dot4su_sat_add.sv
// -----------------------------------------------------------------------------
// dot4su_sat_add
//
// Combinational signed adder: ACC_W-bit accumulator plus a sign-extended
// PROD_W-bit product.
//
// Ports:
//   acc_i    in  ACC_W   current signed accumulator value
//   addend_i in  PROD_W  signed product to add
//   sum_o    out ACC_W   signed sum (wrapped, or saturated with DOT4SU_SAT_EN)
//   ovf_o    out 1       the true sum does not fit in ACC_W signed bits
//
// Configuration:
//   DOT4SU_SAT_EN defined   : an overflowing sum clamps to the signed limit on
//                             the side it overflowed towards.
//   DOT4SU_SAT_EN undefined : an overflowing sum wraps modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module dot4su_sat_add
  import dot4su_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [PROD_W-1:0] addend_i,
  output logic signed [ACC_W-1:0]  sum_o,
  output logic                     ovf_o
);

  logic signed [ACC_W-1:0] addend_ext;
  logic signed [ACC_W-1:0] raw_sum;

  // Size cast of a signed operand sign-extends, and stays legal when
  // ACC_W == PROD_W (a replication count of zero would not be).
  assign addend_ext = ACC_W'(addend_i);
  assign raw_sum    = acc_i + addend_ext;

  // Two's-complement overflow: operands share a sign and the sum does not.
  assign ovf_o = (acc_i[ACC_W-1] == addend_ext[ACC_W-1]) &&
                 (raw_sum[ACC_W-1] != acc_i[ACC_W-1]);

`ifdef DOT4SU_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // On overflow both operands had the sign of acc_i, so that sign tells the
  // direction of the overflow.
  always_comb begin
    sum_o = raw_sum;
    if (ovf_o) begin
      sum_o = acc_i[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign sum_o = raw_sum;
`endif

endmodule : dot4su_sat_add

// File: rtl/dot4su_acc.sv
// -----------------------------------------------------------------------------
// dot4su_acc
//
// Streaming dot-product accumulator. Sums LEN consecutive signed products into
// an ACC_W-bit signed accumulator and presents the finished sum, with a sticky
// overflow flag, on a valid/ready output port.
//
// Parameters:
//   ACC_W  accumulator / result width (8..32)
//   LEN    products per dot product (2..256)
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      asynchronous active-high reset
//   clear      in  1      synchronous abort of the dot product in flight;
//                         also drops a waiting result (result value is kept)
//   in_valid   in  1      prod is valid
//   in_ready   out 1      prod is accepted this cycle
//   prod       in  8      signed product
//   out_valid  out 1      result / ovf are valid
//   out_ready  in  1      consumer takes the result
//   result     out ACC_W  signed dot product
//   ovf        out 1      some intermediate sum of that dot product overflowed
//   dbg_state  out 1      FSM state (ACCUM / HOLD) for observation
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. out_valid, once raised, stays high with result/ovf stable
// until out_ready is seen. in_ready depends only on out_valid and out_ready,
// never on in_valid, so there is no combinational loop back to the producer.
//
// Configuration macro: DOT4SU_SAT_EN (saturating accumulation, see
// dot4su_sat_add). Default build wraps.
// -----------------------------------------------------------------------------
module dot4su_acc
  import dot4su_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int LEN   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] prod,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  result,
  output logic                     ovf,
  output state_e                   dbg_state
);

  localparam int                CNT_W = cnt_width(LEN);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(LEN - 1);

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] result_q;
  logic                    out_valid_q;
  logic                    ovf_q;
  logic                    ovf_run_q;

  logic signed [ACC_W-1:0] sum_d;
  logic                    add_ovf_d;
  logic                    accept;
  logic                    final_term;
  logic                    drain;

  dot4su_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i    (acc_q),
    .addend_i (prod),
    .sum_o    (sum_d),
    .ovf_o    (add_ovf_d)
  );

  // The output register is free when empty or being drained this cycle, so a
  // final term can land in the same cycle the old result leaves.
  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign final_term = (cnt_q == LAST);
  assign drain      = out_valid_q && out_ready;

  // Single FSM block. Later assignments win: a final term accepted while the
  // old result drains keeps out_valid high and the state in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      ovf_run_q   <= 1'b0;
    end else if (clear) begin
      // Abort wins over any handshake in the same cycle; result_q/ovf_q keep
      // their last value.
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_run_q   <= 1'b0;
    end else begin
      if (drain) begin
        out_valid_q <= 1'b0;
        state_q     <= ACCUM;
      end
      if (accept) begin
        if (final_term) begin
          result_q    <= sum_d;
          ovf_q       <= ovf_run_q | add_ovf_d;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_run_q   <= 1'b0;
        end else begin
          acc_q     <= sum_d;
          cnt_q     <= cnt_q + 1'b1;
          ovf_run_q <= ovf_run_q | add_ovf_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule : dot4su_acc
